// File: rtl/uart_wb_pkg.sv
// rtl/uart_wb_pkg.sv - shared constants and state type for the UART-to-Wishbone debug bridge
// Exports: CMD_WRITE, CMD_READ (host command bytes), RSP_ACK, RSP_NAK (bridge reply bytes),
//          s_bridge_t (bridge FSM state).
package uart_wb_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_ACK,
    S_RESP,
    S_RESP_WAIT
  } s_bridge_t;

endpackage

// File: rtl/if_wb.sv
// rtl/if_wb.sv - pipelined Wishbone bus bundle, 32-bit data and address
// master modport drives cyc, stb, we, adr, sel, dat_o; receives dat_i, ack, stall.
interface if_wb;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_o,
    input  dat_i, ack, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_o,
    output dat_i, ack, stall
  );

endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, one-cycle ready pulse per good byte
// Ports: clk_i, rst_i (sync active-high), rx (serial in, idle high),
//        data[7:0] (last received byte), ready (pulse when data is new).
module uart_rx #(
  parameter int CLKFREQ = 50000000,
  parameter int BAUD    = 9600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx,
  output logic [7:0] data,
  output logic       ready
);

  localparam int          DIV    = CLKFREQ / BAUD;
  localparam logic [15:0] BIT_M1 = 16'(DIV - 1);
  // Half a bit to reach mid-start-bit, less the two synchronizer stages.
  localparam logic [15:0] HALF   = 16'((DIV / 2) - 2);

  logic        rx_s1, rx_s2, active;
  logic [15:0] cnt;
  logic [3:0]  bit_idx;
  logic [7:0]  shift;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data    <= '0;
      ready   <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      ready <= 1'b0;
      if (!active) begin
        if (!rx_s2) begin
          active  <= 1'b1;
          cnt     <= HALF;
          bit_idx <= '0;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 16'd1;
      end else begin
        cnt     <= BIT_M1;
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == 4'd0) begin
          // Glitch rather than a real start bit.
          if (rx_s2) active <= 1'b0;
        end else if (bit_idx <= 4'd8) begin
          shift <= {rx_s2, shift[7:1]};
        end else begin
          active <= 1'b0;
          // Framing error (stop bit low) drops the byte silently.
          if (rx_s2) begin
            data  <= shift;
            ready <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter
// Ports: clk_i, rst_i (sync active-high), start (load data when ready), data[7:0],
//        tx (serial out, idle high), ready (high when idle and able to accept start).
module uart_tx #(
  parameter int CLKFREQ = 50000000,
  parameter int BAUD    = 9600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int          DIV    = CLKFREQ / BAUD;
  localparam logic [15:0] BIT_M1 = 16'(DIV - 1);

  logic        active;
  logic [9:0]  shreg;
  logic [15:0] cnt;
  logic [3:0]  bits;

  assign ready = ~active;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active <= 1'b0;
      shreg  <= '1;
      cnt    <= '0;
      bits   <= '0;
      tx     <= 1'b1;
    end else if (!active) begin
      if (start) begin
        shreg  <= {1'b1, data, 1'b0};
        tx     <= 1'b0;
        cnt    <= BIT_M1;
        bits   <= '0;
        active <= 1'b1;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 16'd1;
    end else if (bits == 4'd9) begin
      // Stop bit has been held a full bit time.
      active <= 1'b0;
      tx     <= 1'b1;
    end else begin
      shreg <= {1'b1, shreg[9:1]};
      tx    <= shreg[1];
      bits  <= bits + 4'd1;
      cnt   <= BIT_M1;
    end
  end

endmodule

// File: rtl/uart_wb_master.sv
// rtl/uart_wb_master.sv - UART command frames to single 32-bit Wishbone master cycles
// Ports: clk_i, rst_i (sync active-high), bus (Wishbone master), rx (host serial in),
//        tx (host serial out), busy (command in progress until reply fully sent).
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int CLKFREQ = 50000000,
  parameter int BAUD    = 9600,
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  if_wb.master bus,
  input  logic rx,
  output logic tx,
  output logic busy
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  s_bridge_t   state, state_n;
  logic [7:0]  rx_data;
  logic        rx_ready, tx_ready;
  logic        tx_start_q;
  logic [7:0]  tx_byte_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        is_write_q, nak_q, tx_low_q;
  logic [1:0]  byte_cnt_q, rsp_idx_q;
  logic [15:0] tmo_q;
  logic        cyc;
  logic [7:0]  rsp_byte;
  logic        rsp_last;
  logic        accept_cmd, shift_addr, shift_data, latch_rd, set_nak, send_byte, byte_done;

  uart_rx #(.CLKFREQ(CLKFREQ), .BAUD(BAUD)) u_rx (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx    (rx),
    .data  (rx_data),
    .ready (rx_ready)
  );

  uart_tx #(.CLKFREQ(CLKFREQ), .BAUD(BAUD)) u_tx (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .start (tx_start_q),
    .data  (tx_byte_q),
    .tx    (tx),
    .ready (tx_ready)
  );

  assign cyc       = (state == S_BUS) || (state == S_ACK);
  assign bus.cyc   = cyc;
  assign bus.stb   = (state == S_BUS);
  assign bus.we    = cyc & is_write_q;
  assign bus.sel   = cyc ? 4'hF : 4'h0;
  assign bus.adr   = addr_q & 32'hFFFF_FFFC;
  assign bus.dat_o = wdata_q;
  assign busy      = (state != S_IDLE);

  // Read data goes out MSB first: index 0 selects bits [31:24].
  assign rsp_byte = nak_q      ? RSP_NAK :
                    is_write_q ? RSP_ACK :
                    rdata_q[{~rsp_idx_q, 3'b000} +: 8];
  assign rsp_last = nak_q || is_write_q || (rsp_idx_q == 2'd3);

  always_comb begin
    state_n    = state;
    accept_cmd = 1'b0;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    latch_rd   = 1'b0;
    set_nak    = 1'b0;
    send_byte  = 1'b0;
    byte_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_ready && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
          accept_cmd = 1'b1;
          state_n    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_ready) begin
          shift_addr = 1'b1;
          if (byte_cnt_q == 2'd3) state_n = is_write_q ? S_DATA : S_BUS;
        end
      end
      S_DATA: begin
        if (rx_ready) begin
          shift_data = 1'b1;
          if (byte_cnt_q == 2'd3) state_n = S_BUS;
        end
      end
      S_BUS: begin
        if (!bus.stall) begin
          // An ack in the accept cycle completes the transfer immediately.
          if (bus.ack) begin
            latch_rd = 1'b1;
            state_n  = S_RESP;
          end else begin
            state_n = S_ACK;
          end
        end else if (tmo_q >= TMO_LAST) begin
          set_nak = 1'b1;
          state_n = S_RESP;
        end
      end
      S_ACK: begin
        if (bus.ack) begin
          latch_rd = 1'b1;
          state_n  = S_RESP;
        end else if (tmo_q >= TMO_LAST) begin
          set_nak = 1'b1;
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          send_byte = 1'b1;
          state_n   = S_RESP_WAIT;
        end
      end
      S_RESP_WAIT: begin
        if (tx_low_q && tx_ready) begin
          byte_done = 1'b1;
          state_n   = rsp_last ? S_IDLE : S_RESP;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
      nak_q      <= 1'b0;
      tx_low_q   <= 1'b0;
      byte_cnt_q <= '0;
      rsp_idx_q  <= '0;
      tmo_q      <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      state      <= state_n;
      tx_start_q <= send_byte;
      if (send_byte) begin
        tx_byte_q <= rsp_byte;
        tx_low_q  <= 1'b0;
      end else if (state == S_RESP_WAIT && !tx_ready) begin
        tx_low_q <= 1'b1;
      end
      if (accept_cmd) begin
        is_write_q <= (rx_data == CMD_WRITE);
        nak_q      <= 1'b0;
        byte_cnt_q <= '0;
        rsp_idx_q  <= '0;
      end
      // The 2-bit counter wraps to 0 after the fourth byte, ready for the data phase.
      if (shift_addr) begin
        addr_q     <= {addr_q[23:0], rx_data};
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (shift_data) begin
        wdata_q    <= {wdata_q[23:0], rx_data};
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (latch_rd && !is_write_q) rdata_q <= bus.dat_i;
      if (set_nak) nak_q <= 1'b1;
      if (byte_done) rsp_idx_q <= rsp_idx_q + 2'd1;
      if (state_n == S_BUS && state != S_BUS) begin
        tmo_q <= '0;
      end else if (cyc && tmo_q != 16'hFFFF) begin
        tmo_q <= tmo_q + 16'd1;
      end
    end
  end

endmodule

// File: doc/uart_wb_master.md
# uart_wb_master

Serial-to-Wishbone debug bridge: receives framed commands on a UART line and issues single 32-bit Wishbone master cycles, then returns the result over the UART transmit line. It sits between an external host (PC terminal or debug script) and the system bus interconnect, acting as the initiator toward slaves such as `uart`, memory and peripheral blocks. One command is handled at a time; there is no FIFO.

## Interface
Parameters:
- `CLKFREQ`, 50000000: `clk_i` frequency in Hz, passed to `uart_rx`/`uart_tx`.
- `BAUD`, 9600: serial bit rate.
- `TIMEOUT`, 1024: clock cycles to wait for `bus.ack` before aborting.

Ports:
- `clk_i`  in  1  single clock, all logic on rising edge.
- `rst_i`  in  1  reset; **synchronous, active-high**.
- `bus`  if_wb.master  –  pipelined Wishbone: cyc, stb, we, adr[31:0], sel[3:0], dat_o[31:0] (write data), dat_i[31:0], ack, stall.
- `rx`  in  1  serial input from host, idle high.
- `tx`  out  1  serial output to host, idle high.
- `busy`  out  1  high from first accepted command byte until the response's last byte has left `uart_tx`.

## Operation
- Frame, host→bridge: cmd byte, 4 address bytes (MSB first), then 4 data bytes (MSB first) for a write only.
  - `0x57` ('W'): write.
  - `0x52` ('R'): read.
  - Any other byte while idle is discarded; no response.
- Response, bridge→host:
  - write OK: `0x06`.
  - read OK: 4 data bytes, MSB first.
  - bus timeout, either command: `0x15`.
- `bus.adr` = received address with bits [1:0] forced to 0. `bus.sel` = 4'hF always. `bus.we` = 1 for 'W'.
- States:
  - S_IDLE: accept cmd byte → S_ADDR; byte counter cleared.
  - S_ADDR: 4 bytes shifted into addr; → S_DATA (write) or S_BUS (read).
  - S_DATA: 4 bytes shifted into wdata; → S_BUS.
  - S_BUS: cyc=stb=1; when stall=0 → S_ACK with stb=0, cyc held.
  - S_ACK: on ack, latch `dat_i` for reads, drop cyc, → S_RESP. If the timeout counter reaches TIMEOUT-1, drop cyc, set nak, → S_RESP.
  - S_RESP: wait for `uart_tx` ready, pulse start for one cycle with the current byte → S_RESP_WAIT.
  - S_RESP_WAIT: wait for ready to go low, then high again. Increment the response index. Loop to S_RESP until all bytes are sent (1 byte, or 4 for a read OK), then → S_IDLE.
- `uart_rx` ready pulses outside S_IDLE/S_ADDR/S_DATA are dropped.
- The timeout counter also covers S_BUS: a stall held for TIMEOUT cycles aborts with NAK.

## Timing
- Reset values: cyc=0, stb=0, we=0, adr=0, sel=0, dat_o=0, busy=0, tx=1; state S_IDLE, counters 0.
- Reset mid-cycle: cyc/stb are low on the cycle after `rst_i` is sampled high; any partially received or sent frame is abandoned.
- cyc and stb rise on the cycle after the last frame byte's `uart_rx` ready pulse.
- stb is high for exactly one cycle when stall=0, and stays high while stall=1.
- An ack arriving in the same cycle stb is accepted is honoured: skip the wait, go straight to S_RESP.
- ack and timeout expiring in the same cycle: ack wins.
- Timeout counter is 16 bits, cleared on entry to S_BUS, and saturates (no wrap).
- Minimum cycle from cmd ack to `uart_tx` start is 2 clocks.

## Structure
- Package `uart_wb_pkg`:
  - command/response constants (CMD_WRITE, CMD_READ, RSP_ACK, RSP_NAK);
  - state enum `s_bridge_t`;
  - shared with the host-side test model.
- Existing `uart_rx` and `uart_tx` are instantiated unchanged.
- Framing FSM and bus FSM stay in one module; a separate sub-module is not warranted.

## Test plan
- Host sends `57 00 00 10 04 DE AD BE EF`; slave acks after 3 cycles → one write cycle with adr=0x00001004, dat_o=0xDEADBEEF, sel=F, we=1; tx returns `06`.
- Host sends `52 00 00 20 00`; slave returns dat_i=0x12345678 → we=0, adr=0x00002000; tx returns `12 34 56 78`.
- Slave holds stall=1 for 5 cycles → stb stays high 6 cycles total, then one cycle with stb=0 while cyc is held until ack.
- No ack, TIMEOUT=16 → cyc drops 16 cycles after stb acceptance; tx returns `15`; a following valid read completes normally.
- Host sends `41` then a valid read → `41` is ignored, no bus cycle and no response for it; the read completes.
- `rst_i` asserted while in S_ACK → cyc=0 next cycle, busy=0, no response byte on tx.
